// File: rtl/fetch_queue_if.sv
// Bundle of fetch-side signals: instruction ROM port, redirect/irq inputs and
// the decode-facing valid/ready queue head.
interface fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic [31:0]    imem_addr;
    logic [31:0]    imem_rdata;
    logic           redirect_valid;
    logic [31:0]    redirect_pc;
    logic           irq;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_instr;
    logic [31:0]    out_pc_plus4;
    logic           out_irq;
    logic [PTR_W:0] occupancy;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  irq,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc_plus4,
        output out_irq,
        output occupancy
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output irq,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc_plus4,
        input  out_irq,
        input  occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry queue of
// {instr, pc+4, irq tag}, drained by decode and flushed by redirects.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PTR_W    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_irq_lock;

    logic [31:0]      w_next_pc;
    logic [31:0]      w_redirect_pc;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_fetch;
    logic             w_tag;
    logic [64:0]      w_entry [DEPTH];
    logic [64:0]      w_head;

    // Bit 31 is the kernel bit; increments wrap only within the low 31 bits.
    assign w_next_pc     = {r_fetch_pc[31], r_fetch_pc[30:0] + 31'd4};
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_valid       = (r_count != '0);
    assign w_full        = (r_count == DEPTH_C);
    assign w_pop         = w_valid & bus.out_ready & ~bus.redirect_valid;
    assign w_fetch       = ~bus.redirect_valid & (~w_full | w_pop);
    assign w_tag         = bus.irq & ~r_fetch_pc[31] & ~r_irq_lock;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_irq_lock <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_irq_lock <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_fetch_pc <= w_next_pc;
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                if (w_tag) begin
                    r_irq_lock <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_fetch && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop && !w_fetch) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    // Entry payload is not reset; the empty-gating on the outputs hides stale data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [64:0] r_entry;
            always_ff @(posedge clk) begin
                if (!reset && w_fetch && (r_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= {bus.imem_rdata, w_next_pc, w_tag};
                end
            end
            assign w_entry[gi] = r_entry;
        end
    endgenerate

    assign w_head = w_entry[r_rd_ptr];

    assign bus.imem_addr    = r_fetch_pc;
    assign bus.out_valid    = w_valid;
    assign bus.out_instr    = w_valid ? w_head[64:33] : 32'h0;
    assign bus.out_pc_plus4 = w_valid ? w_head[32:1]  : 32'h0;
    assign bus.out_irq      = w_valid & w_head[0];
    assign bus.occupancy    = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an address-as-data instruction ROM.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_queue_if #(.PTR_W(2)) bus ();

    assign bus.imem_rdata = bus.imem_addr;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .PTR_W    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.irq            = 1'b0;
        bus.out_ready      = 1'b1;

        // Reset state and streaming with decode always ready
        step();
        check("rst_occ",   32'(bus.occupancy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pc4",   bus.out_pc_plus4, 32'h0);
        check("rst_irq",   32'(bus.out_irq), 32'd0);
        check("rst_addr",  bus.imem_addr, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("strm_valid", 32'(bus.out_valid), 32'd1);
            check("strm_instr", bus.out_instr, 32'(4 * k));
            check("strm_pc4",   bus.out_pc_plus4, 32'(4 * k + 4));
            check("strm_occ",   32'(bus.occupancy), 32'd1);
        end

        // Fill with decode stalled, then drain
        reset = 1'b1; bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("fill_occ", 32'(bus.occupancy), 32'(k));
        end
        step();
        check("full_occ",   32'(bus.occupancy), 32'd4);
        check("full_addr",  bus.imem_addr, 32'h10);
        check("full_head",  bus.out_instr, 32'h0);
        bus.out_ready = 1'b1;
        step();
        check("drain_head", bus.out_instr, 32'h4);
        check("drain_occ",  32'(bus.occupancy), 32'd4);
        check("drain_addr", bus.imem_addr, 32'h14);
        step();
        check("drain_head", bus.out_instr, 32'h8);
        step();
        check("drain_head", bus.out_instr, 32'hC);
        step();
        check("refill_head", bus.out_instr, 32'h10);
        check("refill_pc4",  bus.out_pc_plus4, 32'h14);

        // Redirect with three entries queued and a simultaneous out_ready
        reset = 1'b1; bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        check("pre_redir_occ", 32'(bus.occupancy), 32'd3);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0403; bus.out_ready = 1'b1;
        step();
        check("redir_occ",   32'(bus.occupancy), 32'd0);
        check("redir_valid", 32'(bus.out_valid), 32'd0);
        check("redir_addr",  bus.imem_addr, 32'h400);
        bus.redirect_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        check("redir_instr", bus.out_instr, 32'h400);
        check("redir_pc4",   bus.out_pc_plus4, 32'h404);
        check("redir_occ1",  32'(bus.occupancy), 32'd1);

        // IRQ tagging in user mode, lock, kernel-mode masking, lock release
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20; bus.out_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b0; bus.irq = 1'b1;
        step();
        check("irq_instr", bus.out_instr, 32'h20);
        check("irq_tag",   32'(bus.out_irq), 32'd1);
        step();
        check("irq_instr2", bus.out_instr, 32'h24);
        check("irq_lock1",  32'(bus.out_irq), 32'd0);
        step();
        check("irq_lock2",  32'(bus.out_irq), 32'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0004;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("kern_instr", bus.out_instr, 32'h8000_0004);
        check("kern_irq",   32'(bus.out_irq), 32'd0);
        step();
        check("kern_irq2",  32'(bus.out_irq), 32'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("unlock_instr", bus.out_instr, 32'h40);
        check("unlock_irq",   32'(bus.out_irq), 32'd1);

        // Increment carries within low bits and preserves bit 31
        bus.irq = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0FFC;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("k_instr", bus.out_instr, 32'h8000_0FFC);
        check("k_pc4a",  bus.out_pc_plus4, 32'h8000_1000);
        step();
        check("k_pc4b",  bus.out_pc_plus4, 32'h8000_1004);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h7FFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("wrap_pc4",   bus.out_pc_plus4, 32'h0);
        step();
        check("wrap_instr", bus.out_instr, 32'h0);
        check("wrap_pc4b",  bus.out_pc_plus4, 32'h4);

        // Reset overrides a simultaneous redirect and clears the irq lock
        bus.out_ready = 1'b0; bus.irq = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        step(); step();
        check("pre_rst_occ", 32'(bus.occupancy), 32'd2);
        reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        step();
        check("rr_occ",   32'(bus.occupancy), 32'd0);
        check("rr_addr",  bus.imem_addr, 32'h0);
        check("rr_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0; bus.redirect_valid = 1'b0;
        step();
        check("rr_instr", bus.out_instr, 32'h0);
        check("rr_irq",   32'(bus.out_irq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parameterised instruction-fetch front end for the pipelined MIPS core.
- Replaces the single-entry PC register and IF/ID latch with a PC generator plus a DEPTH-entry FIFO of fetched instructions.
- Decode consumes entries via valid/ready; EX/ID branch and jump resolution, exceptions and IRQ entry redirect the front end with a single-cycle flush.
- Sits between the combinational instruction ROM and the decode/control stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- PTR_W, 2, pointer width = log2(DEPTH); must match DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  fetch address to instruction ROM; equals fetch_pc at all times.
- imem_rdata  input  32  ROM data for imem_addr, same cycle (combinational ROM).
- redirect_valid  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
- irq  input  1  level interrupt request from peripheral block.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry this cycle.
- out_instr  output  32  head instruction word.
- out_pc_plus4  output  32  PC+4 of head instruction (link/branch base).
- out_irq  output  1  head entry tagged for interrupt entry.
- occupancy  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (synchronous, reset=1 at edge): fetch_pc=RESET_PC; rd/wr pointers=0; count=0; irq_lock=0. Outputs out_valid=0, occupancy=0, out_instr=0, out_pc_plus4=0, out_irq=0.
- Storage: per entry {instr[31:0], pc_plus4[31:0], irq_tag}.
  - Outputs are driven from registered head entry only; no ROM-to-output combinational path.
  - out_instr, out_pc_plus4 and out_irq read 0 when empty.
- Increment rule: next_pc = {fetch_pc[31], fetch_pc[30:0] + 31'd4}. Bit 31 is the kernel/supervisor bit and never changes by increment; bits [30:0] wrap 7FFF_FFFC -> 0000_0000.
- pop = out_valid & out_ready & ~redirect_valid.
- fetch = ~redirect_valid & (count < DEPTH | pop).
  - When fetch=1: write {imem_rdata, next_pc, tag} at wr_ptr, wr_ptr++, fetch_pc <= next_pc.
  - When full with no pop: no write, fetch_pc holds.
- count: +1 on fetch only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Latency: an instruction fetched at cycle N is visible on out_* at N+1. Empty-queue throughput is 1 instruction/cycle; a full queue with pop every cycle sustains 1/cycle.
- Redirect (highest priority):
  - At the edge: count=0, rd_ptr=wr_ptr=0, fetch_pc <= {redirect_pc[31:2],2'b00}, irq_lock=0, no fetch, no pop.
  - out_valid=0 on cycle R+1; fetch from new PC at R+1; first new entry valid at R+2.
  - A simultaneous out_ready is ignored; decode must not treat the head as consumed on a redirect cycle.
- IRQ tagging:
  - tag = irq & ~fetch_pc[31] & ~irq_lock, evaluated on a fetch cycle.
  - When a tagged entry is written, irq_lock <= 1. No further entries are tagged until a redirect, which is the handler jump issued by decode.
  - Fetch never stalls for irq.
  - irq asserted while fetch_pc[31]=1 (kernel mode) is ignored, with no pending memory.
- Reset mid-operation overrides redirect, fetch and pop in the same cycle.
- Full and empty are derived from count only, never from pointer equality.

Test Plan:
- Reset, then out_ready=1 with ROM returning addr-as-data.
  - First out_valid at cycle 2 after reset release with out_instr=0x0, out_pc_plus4=0x4.
  - Then one entry per cycle: 0x4/0x8, 0x8/0xC, and so on.
  - occupancy stays at 1.
- out_ready=0 from reset, DEPTH=4.
  - occupancy goes 1,2,3,4 then holds; imem_addr holds at 0x10.
  - Raising out_ready then drains entries 0x0..0xC in order with no skipped or duplicated entries, and refill resumes at 0x10.
- Queue holding 3 entries; redirect_valid=1 with redirect_pc=0x0000_0403 and out_ready=1 on the same cycle.
  - Next cycle: occupancy=0, out_valid=0.
  - Following cycle: out_instr=0x400, out_pc_plus4=0x404.
- irq=1 held while fetching from 0x20 in user mode.
  - Exactly the entry for 0x20 has out_irq=1; later entries have out_irq=0.
  - After a redirect to 0x8000_0004, entries carry out_irq=0 because the PC is in kernel mode.
- fetch_pc=0x8000_0FFC, out_ready=1.
  - Next entries report out_pc_plus4=0x8000_1000, then 0x8000_1004.
  - A separate run with fetch_pc=0x7FFF_FFFC gives out_pc_plus4=0x0000_0000, confirming bit 31 is preserved.
- With 2 entries queued, pulse reset together with redirect_valid.
  - Next cycle: occupancy=0, imem_addr=RESET_PC, irq_lock cleared.
